// File: rtl/simple_serial_seq_pkg.sv
// Shared types for the simple_serial command sequencer: FSM states, queued command and response formats.
// LEN_MAX is the widest legal shift; out-of-range lengths are clamped to it.
package simple_serial_seq_pkg;

  localparam int SSEQ_DATA_W = 32;
  localparam int SSEQ_LEN_W  = 6;
  localparam int LEN_MAX     = SSEQ_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT,
    SETTLE,
    STORE
  } state_t;

  typedef struct packed {
    logic [SSEQ_DATA_W-1:0] data;
    logic [SSEQ_LEN_W-1:0]  len;
  } cmd_t;

  typedef struct packed {
    logic                   err;
    logic [SSEQ_DATA_W-1:0] data;
  } rsp_t;

  // Zero means "full word" to software, so it maps to LEN_MAX like any oversize value.
  function automatic logic [31:0] clamp_len(input logic [SSEQ_LEN_W-1:0] len);
    if (len == '0 || 32'(len) > 32'(LEN_MAX)) begin
      return 32'(LEN_MAX);
    end
    return 32'(len);
  endfunction

endpackage

// File: rtl/sseq_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output; head data valid whenever rd_vld.
// Zero-cycle read latency; wr_rdy drops when full unless a pop happens in the same cycle.
module sseq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             wr_fire;
  logic             rd_fire;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd_vld  = (level != '0);
  assign rd_fire = rd_vld && rd_rdy;
  assign wr_rdy  = !full || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/simple_serial_sequencer.sv
// Queues serial commands, triggers the engine one at a time and collects read words; trigger 3 cycles after accept into an idle queue, rsp 2 cycles after the count change is seen.
// Never launches without a free rsp slot (stalls, never drops); SSEQ_TIMEOUT_EN adds a WAIT abort that returns an error response.
module simple_serial_sequencer
  import simple_serial_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = SSEQ_DATA_W,
  parameter int LEN_W  = SSEQ_LEN_W
`ifdef SSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        ser_write_data,
  output logic [31:0]              ser_data_len,
  output logic                     ser_trigger,
  input  logic [DATA_W-1:0]        ser_read_data,
  input  logic [31:0]              ser_transaction_count,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_level,
  output logic [$clog2(DEPTH):0]   rsp_level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_t      state;
  cmd_t        cmd_in;
  cmd_t        cmd_head;
  rsp_t        rsp_in;
  rsp_t        rsp_head;
  logic        cmd_head_vld;
  logic        cmd_pop;
  logic        rsp_push;
  logic        rsp_wr_rdy;
  logic        rsp_free;
  logic [31:0] cnt_snap;

  assign cmd_in  = {cmd_data, cmd_len};
  assign cmd_pop = (state == LOAD);
  assign busy    = (state != IDLE);

  // A pop in the same cycle frees a slot, so a drained-by-one rsp FIFO restarts without a bubble.
  assign rsp_free = (rsp_level != LVL_W'(DEPTH)) || (rsp_valid && rsp_ready);

  assign rsp_data = rsp_valid ? rsp_head.data : '0;
  assign rsp_err  = rsp_valid ? rsp_head.err  : 1'b0;

`ifdef SSEQ_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        to_flag;

  assign rsp_push = ((state == SETTLE) || (state == STORE && to_flag)) && rsp_wr_rdy;
  assign rsp_in   = {to_flag, (to_flag ? {DATA_W{1'b0}} : ser_read_data)};
`else
  assign rsp_push = (state == SETTLE) && rsp_wr_rdy;
  assign rsp_in   = {1'b0, ser_read_data};
`endif

  sseq_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk    (axi_clk),
    .rst    (axi_rst),
    .wr_vld (cmd_valid),
    .wr_rdy (cmd_ready),
    .wr_dat (cmd_in),
    .rd_vld (cmd_head_vld),
    .rd_rdy (cmd_pop),
    .rd_dat (cmd_head),
    .level  (cmd_level)
  );

  sseq_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk    (axi_clk),
    .rst    (axi_rst),
    .wr_vld (rsp_push),
    .wr_rdy (rsp_wr_rdy),
    .wr_dat (rsp_in),
    .rd_vld (rsp_valid),
    .rd_rdy (rsp_ready),
    .rd_dat (rsp_head),
    .level  (rsp_level)
  );

  // The rsp write is issued from SETTLE and commits on the edge into STORE,
  // so read_data has been stable for a full cycle after the count moved.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state          <= IDLE;
      ser_write_data <= '0;
      ser_data_len   <= '0;
      ser_trigger    <= 1'b0;
      cnt_snap       <= '0;
`ifdef SSEQ_TIMEOUT_EN
      wait_cnt       <= '0;
      to_flag        <= 1'b0;
`endif
    end else begin
      ser_trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_head_vld && rsp_free) state <= LOAD;
        end
        LOAD: begin
          ser_write_data <= cmd_head.data;
          ser_data_len   <= clamp_len(cmd_head.len);
          cnt_snap       <= ser_transaction_count;
          ser_trigger    <= 1'b1;
          state          <= LAUNCH;
`ifdef SSEQ_TIMEOUT_EN
          wait_cnt       <= '0;
          to_flag        <= 1'b0;
`endif
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          // Inequality rather than +1 so a wrapping counter still completes.
          if (ser_transaction_count != cnt_snap) begin
            state <= SETTLE;
          end
`ifdef SSEQ_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
            to_flag <= 1'b1;
            state   <= STORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        SETTLE:  state <= STORE;
        STORE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_serial_sequencer.sv
// Directed bench for simple_serial_sequencer: single transfer, queue fill, rsp back-pressure, count wrap, reset in WAIT, optional timeout.
module tb_simple_serial_sequencer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int LVL_W  = 4;

  logic              axi_clk = 1'b0;
  logic              axi_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [DATA_W-1:0] ser_write_data;
  logic [31:0]       ser_data_len;
  logic              ser_trigger;
  logic [DATA_W-1:0] ser_read_data = '0;
  logic [31:0]       ser_transaction_count = 32'd5;
  logic              busy;
  logic [LVL_W-1:0]  cmd_level;
  logic [LVL_W-1:0]  rsp_level;

  int checks   = 0;
  int failures = 0;

  always #5 axi_clk = ~axi_clk;

  simple_serial_sequencer #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
`ifdef SSEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .axi_clk              (axi_clk),
    .axi_rst              (axi_rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_data             (cmd_data),
    .cmd_len              (cmd_len),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data             (rsp_data),
    .rsp_err              (rsp_err),
    .ser_write_data       (ser_write_data),
    .ser_data_len         (ser_data_len),
    .ser_trigger          (ser_trigger),
    .ser_read_data        (ser_read_data),
    .ser_transaction_count(ser_transaction_count),
    .busy                 (busy),
    .cmd_level            (cmd_level),
    .rsp_level            (rsp_level)
  );

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] d, input logic [5:0] l);
    chk("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_trig(input string tag);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      tick();
      n++;
      if (ser_trigger) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Engine finishes while the sequencer is in WAIT; rsp lands two edges later.
  task automatic complete(input logic [31:0] word);
    ser_transaction_count = ser_transaction_count + 1;
    ser_read_data = word;
    tick();
    tick();
  endtask

  logic [5:0]  lens    [9] = '{6'd16, 6'd0, 6'd40, 6'd1, 6'd32, 6'd7, 6'd8, 6'd3, 6'd5};
  logic [31:0] exp_len [9] = '{32'd16, 32'd32, 32'd32, 32'd1, 32'd32, 32'd7, 32'd8, 32'd3, 32'd5};

  initial begin
    logic trig_seen;

    // Reset state
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_trigger", 32'(ser_trigger), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_level", 32'(cmd_level), 32'd0);
    chk("rst_rsp_level", 32'(rsp_level), 32'd0);
    chk("rst_data_len", ser_data_len, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    tick();
    tick();
    axi_rst = 1'b0;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single transfer with exact timing
    push_cmd(32'hA5A5_0001, 6'd16);
    chk("t1_cmd_level", 32'(cmd_level), 32'd1);
    chk("t1_trig_c1", 32'(ser_trigger), 32'd0);
    tick();
    chk("t1_trig_c2", 32'(ser_trigger), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_trig_c3", 32'(ser_trigger), 32'd1);
    chk("t1_len", ser_data_len, 32'd16);
    chk("t1_wdata", ser_write_data, 32'hA5A5_0001);
    tick();
    chk("t1_trig_off", 32'(ser_trigger), 32'd0);
    ser_transaction_count = 32'd6;
    ser_read_data = 32'h1234;
    tick();
    chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", rsp_data, 32'h1234);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_popped", 32'(rsp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Fill: one in flight plus eight queued, engine stalled
    for (int i = 0; i < 9; i++) begin
      chk("fill_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = 32'h100 + 32'(i);
      cmd_len   = lens[i];
      tick();
    end
    chk("fill_level", 32'(cmd_level), 32'd8);
    chk("fill_not_ready", 32'(cmd_ready), 32'd0);
    cmd_data = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    cmd_valid = 1'b0;
    chk("fill_9th_rejected", 32'(cmd_level), 32'd8);
    chk("fill_first_wdata", ser_write_data, 32'h100);
    chk("fill_first_len", ser_data_len, 32'd16);

    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        wait_trig("fill_trig");
        chk("fill_wdata", ser_write_data, 32'h100 + 32'(k));
        chk("fill_len", ser_data_len, exp_len[k]);
        chk("fill_cmd_level", 32'(cmd_level), 32'(8 - k));
        tick();
      end
      complete(32'hC000 + 32'(k));
      chk("fill_rsp_level", 32'(rsp_level), 32'(k + 1));
    end

    // rsp FIFO full: no launch while a cmd waits
    trig_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      trig_seen = trig_seen | ser_trigger;
    end
    chk("bp_no_trigger", 32'(trig_seen), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_rsp_full", 32'(rsp_level), 32'd8);
    chk("bp_cmd_waiting", 32'(cmd_level), 32'd1);
    chk("bp_head", rsp_data, 32'hC000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_pop_trig0", 32'(ser_trigger), 32'd0);
    chk("bp_pop_busy", 32'(busy), 32'd1);
    tick();
    chk("bp_trig_after_pop", 32'(ser_trigger), 32'd1);
    chk("bp_wdata", ser_write_data, 32'h108);
    chk("bp_len", ser_data_len, 32'd5);
    tick();
    complete(32'hC008);

    rsp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("drain_valid", 32'(rsp_valid), 32'd1);
      chk("drain_order", rsp_data, 32'hC001 + 32'(j));
      tick();
    end
    rsp_ready = 1'b0;
    chk("drain_empty", 32'(rsp_valid), 32'd0);

    // Counter wrap, with the change arriving during LAUNCH
    ser_transaction_count = 32'hFFFF_FFFF;
    push_cmd(32'h77, 6'd0);
    wait_trig("wrap_trig");
    chk("wrap_len_clamp", ser_data_len, 32'd32);
    ser_transaction_count = 32'h0;
    ser_read_data = 32'hBEEF;
    tick();
    chk("wrap_rsp_c1", 32'(rsp_valid), 32'd0);
    tick();
    chk("wrap_rsp_c2", 32'(rsp_valid), 32'd0);
    tick();
    chk("wrap_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wrap_rsp_data", rsp_data, 32'hBEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while waiting on the engine
    push_cmd(32'h55, 6'd8);
    push_cmd(32'h66, 6'd8);
    wait_trig("rst_trig");
    tick();
    chk("rstw_cmd_level", 32'(cmd_level), 32'd1);
    axi_rst = 1'b1;
    #1;
    chk("rstw_trigger", 32'(ser_trigger), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_cmd_level0", 32'(cmd_level), 32'd0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_wdata", ser_write_data, 32'd0);
    chk("rstw_len", ser_data_len, 32'd0);
    ser_transaction_count = ser_transaction_count + 1;
    ser_read_data = 32'hBAD;
    tick();
    tick();
    axi_rst = 1'b0;
    chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("rstw_no_stale_rsp", 32'(rsp_valid), 32'd0);
    chk("rstw_idle", 32'(busy), 32'd0);

`ifdef SSEQ_TIMEOUT_EN
    // Silent engine: error response after 100 WAIT cycles
    push_cmd(32'h99, 6'd8);
    wait_trig("to_trig");
    for (int i = 0; i < 100; i++) tick();
    chk("to_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_store", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ser_transaction_count = ser_transaction_count + 1;
    tick();
    tick();
    tick();
    chk("to_late_ignored", 32'(rsp_level), 32'd0);
    push_cmd(32'hAA, 6'd4);
    wait_trig("to_next_trig");
    tick();
    complete(32'h4242);
    chk("to_next_valid", 32'(rsp_valid), 32'd1);
    chk("to_next_data", rsp_data, 32'h4242);
    chk("to_next_err", 32'(rsp_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
